// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared definitions for the RV32M multiply/divide unit
// Purpose: op-code encodings (shared with the EX ALU decoder), FSM state
//          encoding and the iteration-counter width helper.
// Ports:   none (package).
// Config:  MULDIV_FAST_MUL_EN is consumed by muldiv_unit, not here.
package muldiv_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Counter must hold the values 0..nb_data.
    function automatic int cnt_width(input int nb_data);
        return $clog2(nb_data + 1);
    endfunction

endpackage

// File: rtl/muldiv_sign_ctrl.sv
// rtl/muldiv_sign_ctrl.sv - operand sign handling and special-case detection
// Purpose: decodes the op, produces operand magnitudes, the result-negate
//          flag, and flags for div-by-zero, signed overflow and unknown op.
// Ports:   i_alu_op, i_data1, i_data2      - request op and operands
//          o_mag1, o_mag2                  - operand magnitudes
//          o_neg                           - negate the unsigned result
//          o_is_div                        - divide/remainder op
//          o_sel_hi                        - take high product half / remainder
//          o_div_zero, o_ovf, o_unknown    - special-case flags
module muldiv_sign_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 5
) (
    input  logic [NB_CTRL-1:0] i_alu_op,
    input  logic [NB_DATA-1:0] i_data1,
    input  logic [NB_DATA-1:0] i_data2,
    output logic [NB_DATA-1:0] o_mag1,
    output logic [NB_DATA-1:0] o_mag2,
    output logic               o_neg,
    output logic               o_is_div,
    output logic               o_sel_hi,
    output logic               o_div_zero,
    output logic               o_ovf,
    output logic               o_unknown
);
    import muldiv_pkg::*;

    localparam logic [NB_DATA-1:0] MOST_NEG = {1'b1, {(NB_DATA-1){1'b0}}};

    logic sgn1;
    logic sgn2;
    logic signed_div;

    always_comb begin
        sgn1       = 1'b0;
        sgn2       = 1'b0;
        signed_div = 1'b0;
        o_is_div   = 1'b0;
        o_sel_hi   = 1'b0;
        o_unknown  = 1'b0;
        case (i_alu_op)
            // Low half of the product is sign-agnostic, so MUL runs unsigned.
            NB_CTRL'(OP_MUL): ;
            NB_CTRL'(OP_MULH): begin
                o_sel_hi = 1'b1;
                sgn1     = i_data1[NB_DATA-1];
                sgn2     = i_data2[NB_DATA-1];
            end
            NB_CTRL'(OP_MULHSU): begin
                o_sel_hi = 1'b1;
                sgn1     = i_data1[NB_DATA-1];
            end
            NB_CTRL'(OP_MULHU): o_sel_hi = 1'b1;
            NB_CTRL'(OP_DIV): begin
                o_is_div   = 1'b1;
                signed_div = 1'b1;
                sgn1       = i_data1[NB_DATA-1];
                sgn2       = i_data2[NB_DATA-1];
            end
            NB_CTRL'(OP_DIVU): o_is_div = 1'b1;
            NB_CTRL'(OP_REM): begin
                o_is_div   = 1'b1;
                o_sel_hi   = 1'b1;
                signed_div = 1'b1;
                sgn1       = i_data1[NB_DATA-1];
                sgn2       = i_data2[NB_DATA-1];
            end
            NB_CTRL'(OP_REMU): begin
                o_is_div = 1'b1;
                o_sel_hi = 1'b1;
            end
            default: o_unknown = 1'b1;
        endcase
    end

    // Negating the most-negative value wraps back onto itself, which is the
    // correct unsigned magnitude 2^(NB_DATA-1).
    assign o_mag1 = sgn1 ? -i_data1 : i_data1;
    assign o_mag2 = sgn2 ? -i_data2 : i_data2;

    // Remainder follows the dividend sign; product and quotient use the XOR.
    assign o_neg      = (o_is_div && o_sel_hi) ? sgn1 : (sgn1 ^ sgn2);
    assign o_div_zero = o_is_div && (i_data2 == '0);
    assign o_ovf      = signed_div && (i_data1 == MOST_NEG) && (&i_data2);

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide unit
// Purpose: accepts one op via valid/ready, iterates one bit per cycle
//          (shift-add multiply, restoring divide), applies sign correction
//          and holds the result until consumed.
// Ports:   i_clk, i_rst                         - clock, sync active-high reset
//          i_valid, o_ready, i_alu_op,
//          i_data1, i_data2, i_tag              - request side
//          o_valid, i_ready, o_result,
//          o_zero, o_tag                        - result side
//          i_flush                              - abort in-flight op
// Config:  MULDIV_FAST_MUL_EN - multiply ops use a single-cycle multiplier
//          and go IDLE->FIX->DONE; otherwise multiply is iterative.
module muldiv_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 5,
    parameter int NB_TAG  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic               o_ready,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic [NB_TAG-1:0]  o_tag,
    input  logic               i_valid,
    input  logic [NB_CTRL-1:0] i_alu_op,
    input  logic [NB_DATA-1:0] i_data1,
    input  logic [NB_DATA-1:0] i_data2,
    input  logic [NB_TAG-1:0]  i_tag,
    input  logic               i_ready,
    input  logic               i_flush
);
    import muldiv_pkg::*;

    localparam int               NB_PROD   = 2 * NB_DATA;
    localparam int               CNT_W     = cnt_width(NB_DATA);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NB_DATA - 1);

    state_e              state_q;
    logic                ready_q;
    logic                valid_q;
    logic [NB_DATA-1:0]  result_q;
    logic [NB_TAG-1:0]   tag_q;
    logic [NB_PROD-1:0]  acc_q;
    logic [NB_DATA-1:0]  mb_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_q;
    logic                is_div_q;
    logic                sel_hi_q;

    logic [NB_DATA-1:0]  mag1;
    logic [NB_DATA-1:0]  mag2;
    logic                neg;
    logic                is_div;
    logic                sel_hi;
    logic                div_zero;
    logic                ovf;
    logic                unknown;

    muldiv_sign_ctrl #(
        .NB_DATA (NB_DATA),
        .NB_CTRL (NB_CTRL)
    ) u_sign_ctrl (
        .i_alu_op   (i_alu_op),
        .i_data1    (i_data1),
        .i_data2    (i_data2),
        .o_mag1     (mag1),
        .o_mag2     (mag2),
        .o_neg      (neg),
        .o_is_div   (is_div),
        .o_sel_hi   (sel_hi),
        .o_div_zero (div_zero),
        .o_ovf      (ovf),
        .o_unknown  (unknown)
    );

    logic               accept;
    logic               special;
    logic [NB_DATA-1:0] special_res;

    assign accept  = i_valid && ready_q && !i_flush;
    assign special = div_zero || ovf || unknown;

    // sel_hi on a divide op means "remainder".
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = sel_hi ? i_data1 : '1;
        end else if (ovf) begin
            special_res = sel_hi ? '0 : i_data1;
        end
    end

    // One iteration step. The first step runs on the accept edge straight
    // from the fresh operands, so BUSY only needs NB_DATA-1 further cycles.
    // Accumulator layout: multiply {partial_hi, multiplier_lo},
    // divide {remainder, dividend/quotient}.
    logic [NB_PROD-1:0] step_in;
    logic [NB_DATA-1:0] step_mb;
    logic               step_div;
    logic [NB_DATA:0]   part;
    logic [NB_DATA:0]   diff;
    logic [NB_DATA:0]   sum;
    logic [NB_PROD-1:0] step_d;

    always_comb begin
        step_in  = (state_q == ST_IDLE) ? {{NB_DATA{1'b0}}, mag1} : acc_q;
        step_mb  = (state_q == ST_IDLE) ? mag2 : mb_q;
        step_div = (state_q == ST_IDLE) ? is_div : is_div_q;
        part     = step_in[NB_PROD-1:NB_DATA-1];
        diff     = part - {1'b0, step_mb};
        sum      = {1'b0, step_in[NB_PROD-1:NB_DATA]}
                 + (step_in[0] ? {1'b0, step_mb} : '0);
        if (step_div) begin
            // Restore (keep the shifted remainder) when the subtract borrows.
            if (!diff[NB_DATA]) begin
                step_d = {diff[NB_DATA-1:0], step_in[NB_DATA-2:0], 1'b1};
            end else begin
                step_d = {part[NB_DATA-1:0], step_in[NB_DATA-2:0], 1'b0};
            end
        end else begin
            step_d = {sum, step_in[NB_DATA-1:1]};
        end
    end

    logic [NB_PROD-1:0] prod;
    logic [NB_DATA-1:0] div_val;
    logic [NB_DATA-1:0] fix_d;

    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        div_val = sel_hi_q ? acc_q[NB_PROD-1:NB_DATA] : acc_q[NB_DATA-1:0];
        if (is_div_q) begin
            fix_d = neg_q ? -div_val : div_val;
        end else begin
            fix_d = sel_hi_q ? prod[NB_PROD-1:NB_DATA] : prod[NB_DATA-1:0];
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [NB_PROD-1:0] fast_prod;
    assign fast_prod = NB_PROD'(mag1) * NB_PROD'(mag2);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
            acc_q    <= '0;
            mb_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tag_q    <= i_tag;
                        mb_q     <= mag2;
                        neg_q    <= neg;
                        is_div_q <= is_div;
                        sel_hi_q <= sel_hi;
                        ready_q  <= 1'b0;
                        if (special) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= ST_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div) begin
                            acc_q   <= fast_prod;
                            state_q <= ST_FIX;
                        end
`endif
                        else begin
                            acc_q   <= step_d;
                            cnt_q   <= CNT_W'(1);
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (i_flush) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end else begin
                        acc_q <= step_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_ITER) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (i_flush) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end else begin
                        result_q <= fix_d;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_flush || i_ready) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_tag    = tag_q;
    assign o_zero   = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int NB_DATA = 32;
    localparam int NB_CTRL = 5;
    localparam int NB_TAG  = 5;
    localparam int BUDGET  = 200;

    localparam logic [4:0] T_MUL    = 5'b01010;
    localparam logic [4:0] T_MULH   = 5'b01011;
    localparam logic [4:0] T_MULHSU = 5'b01100;
    localparam logic [4:0] T_MULHU  = 5'b01101;
    localparam logic [4:0] T_DIV    = 5'b01110;
    localparam logic [4:0] T_DIVU   = 5'b01111;
    localparam logic [4:0] T_REM    = 5'b10000;
    localparam logic [4:0] T_REMU   = 5'b10001;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = NB_DATA + 1;
`endif
    localparam int DIV_LAT = NB_DATA + 1;

    logic               clk;
    logic               rst;
    logic               o_ready;
    logic               o_valid;
    logic [NB_DATA-1:0] o_result;
    logic               o_zero;
    logic [NB_TAG-1:0]  o_tag;
    logic               i_valid;
    logic [NB_CTRL-1:0] i_alu_op;
    logic [NB_DATA-1:0] i_data1;
    logic [NB_DATA-1:0] i_data2;
    logic [NB_TAG-1:0]  i_tag;
    logic               i_ready;
    logic               i_flush;

    muldiv_unit #(
        .NB_DATA (NB_DATA),
        .NB_CTRL (NB_CTRL),
        .NB_TAG  (NB_TAG)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_zero   (o_zero),
        .o_tag    (o_tag),
        .i_valid  (i_valid),
        .i_alu_op (i_alu_op),
        .i_data1  (i_data1),
        .i_data2  (i_data2),
        .i_tag    (i_tag),
        .i_ready  (i_ready),
        .i_flush  (i_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            T_MUL:    begin pu = ua * ub; return pu[31:0]; end
            T_MULH:   begin p = sa * sb; return p[63:32]; end
            T_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            T_MULHU:  begin pu = ua * ub; return pu[63:32]; end
            T_DIV:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            T_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            T_REM:    return (b == 0) ? a : 32'(sa % sb);
            T_REMU:   return (b == 0) ? a : 32'(ua % ub);
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op inside {T_MUL, T_MULH, T_MULHSU, T_MULHU}) return MUL_LAT;
        if (!(op inside {T_DIV, T_DIVU, T_REM, T_REMU})) return 1;
        if (b == 0) return 1;
        if ((op == T_DIV || op == T_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DIV_LAT;
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge, idle again.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res,
                          output logic [4:0] rtag, output logic zr, output int lat);
        i_valid  = 1'b1;
        i_alu_op = op;
        i_data1  = a;
        i_data2  = b;
        i_tag    = tag;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        res  = o_result;
        rtag = o_tag;
        zr   = o_zero;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] res;
    logic [4:0]  rtag;
    logic        zr;
    int          lat;
    int          seen;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_alu_op = '0; i_data1 = '0; i_data2 = '0;
        i_tag = '0; i_ready = 1'b0; i_flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_tag", {27'b0, o_tag}, 32'd0);
        check("rst_zero", {31'b0, o_zero}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{T_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
        vecs.push_back('{T_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT});
        vecs.push_back('{T_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
        vecs.push_back('{T_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT});
        vecs.push_back('{T_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT});
        vecs.push_back('{T_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT});
        vecs.push_back('{T_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT});
        vecs.push_back('{T_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT});
        vecs.push_back('{T_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{T_REMU,   32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{T_DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{T_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1});
        vecs.push_back('{T_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{T_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
        vecs.push_back('{5'b00000, 32'd12,        32'd34,        32'd0,         1});
        vecs.push_back('{T_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT});

        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("vec%0d_ready", i), {31'b0, o_ready}, 32'd1);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), res, rtag, zr, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_tag", i), {27'b0, rtag}, 32'(i + 1));
            check($sformatf("vec%0d_zero", i), {31'b0, zr}, {31'b0, vecs[i].exp == 0});
        end

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            logic [4:0]  tg;
            case ($urandom_range(0, 8))
                0: op = T_MUL;   1: op = T_MULH;  2: op = T_MULHSU; 3: op = T_MULHU;
                4: op = T_DIV;   5: op = T_DIVU;  6: op = T_REM;    7: op = T_REMU;
                default: op = 5'($urandom_range(18, 31));
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(1, 40));
            if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            tg = 5'($urandom);
            run_op(op, a, b, tg, res, rtag, zr, lat);
            check($sformatf("rnd%0d_op%0h_result", i, op), res, ref_model(op, a, b));
            check($sformatf("rnd%0d_lat", i), lat, exp_lat(op, a, b));
            check($sformatf("rnd%0d_tag", i), {27'b0, rtag}, {27'b0, tg});
        end

        // Backpressure in DONE, then a back-to-back request.
        i_valid = 1'b1; i_alu_op = T_DIVU; i_data1 = 32'd100; i_data2 = 32'd7; i_tag = 5'd9;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < BUDGET) begin @(negedge clk); lat++; end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_valid", k), {31'b0, o_valid}, 32'd1);
            check($sformatf("bp%0d_result", k), o_result, 32'd14);
            check($sformatf("bp%0d_tag", k), {27'b0, o_tag}, 32'd9);
            check($sformatf("bp%0d_ready", k), {31'b0, o_ready}, 32'd0);
            @(negedge clk);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("bp_release_ready", {31'b0, o_ready}, 32'd1);
        check("bp_release_valid", {31'b0, o_valid}, 32'd0);
        i_valid = 1'b1; i_alu_op = T_MUL; i_data1 = 32'd7; i_data2 = 32'hFFFF_FFFD; i_tag = 5'd3;
        @(negedge clk);
        i_valid = 1'b0;
        check("b2b_accepted", {31'b0, o_ready}, 32'd0);
        lat = 1;
        while (!o_valid && lat < BUDGET) begin @(negedge clk); lat++; end
        check("b2b_lat", lat, MUL_LAT);
        check("b2b_result", o_result, 32'hFFFF_FFEB);
        check("b2b_tag", {27'b0, o_tag}, 32'd3);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;

        // Flush at iteration 10 of a divide.
        i_valid = 1'b1; i_alu_op = T_DIV; i_data1 = 32'd1000; i_data2 = 32'd3; i_tag = 5'd4;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (8) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        check("flush_ready", {31'b0, o_ready}, 32'd1);
        check("flush_valid", {31'b0, o_valid}, 32'd0);
        seen = 0;
        repeat (40) begin @(negedge clk); if (o_valid) seen++; end
        check("flush_no_result", seen, 0);

        // Flush together with a request in IDLE: not accepted.
        i_valid = 1'b1; i_flush = 1'b1; i_alu_op = T_DIV; i_data1 = 32'd5; i_data2 = 32'd0;
        @(negedge clk);
        i_valid = 1'b0; i_flush = 1'b0;
        check("idle_flush_ready", {31'b0, o_ready}, 32'd1);
        check("idle_flush_valid", {31'b0, o_valid}, 32'd0);

        // Flush in DONE wins over a pending result.
        i_valid = 1'b1; i_alu_op = T_DIV; i_data1 = 32'd5; i_data2 = 32'd0; i_tag = 5'd6;
        @(negedge clk);
        i_valid = 1'b0;
        check("done_flush_pre_valid", {31'b0, o_valid}, 32'd1);
        i_flush = 1'b1; i_ready = 1'b1;
        @(negedge clk);
        i_flush = 1'b0; i_ready = 1'b0;
        check("done_flush_valid", {31'b0, o_valid}, 32'd0);
        check("done_flush_ready", {31'b0, o_ready}, 32'd1);

        // Reset in the middle of a multiply.
        i_valid = 1'b1; i_alu_op = T_MUL; i_data1 = 32'h12345; i_data2 = 32'h777; i_tag = 5'd21;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", {31'b0, o_ready}, 32'd1);
        check("midrst_valid", {31'b0, o_valid}, 32'd0);
        check("midrst_result", o_result, 32'd0);
        check("midrst_tag", {27'b0, o_tag}, 32'd0);
        check("midrst_zero", {31'b0, o_zero}, 32'd1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (o_valid) seen++; end
        check("midrst_no_result", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
